// File: rtl/uart_frame_pkg.sv
// Shared types, defaults and checksum helper for the UART frame decoder.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        SYNC0,
        SYNC1,
        LEN,
        PAYLOAD,
        CHECK,
        DRAIN
    } state_t;

    localparam logic [7:0]  DEFAULT_SYNC_BYTE   = 8'hCA;
    localparam int unsigned DEFAULT_MAX_PAYLOAD = 16;

    // Running 8-bit additive checksum step; wraps modulo 256.
    function automatic logic [7:0] checksum_add(input logic [7:0] acc, input logic [7:0] data);
        return acc + data;
    endfunction

endpackage

// File: rtl/uart_frame_buffer.sv
// Payload register file: one write port (capture) and one combinational read port (drain).
module uart_frame_buffer
    import uart_frame_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_MAX_PAYLOAD,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data_c
);

    logic [7:0] mem [DEPTH];

    // Capture payload bytes; storage needs no reset since LEN bounds every read.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/uart_frame_decoder.sv
// Sync-hunting, length-prefixed, checksum-verified byte framer feeding the policy command stream.
module uart_frame_decoder
    import uart_frame_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int unsigned MAX_PAYLOAD    = DEFAULT_MAX_PAYLOAD,
    parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_in_valid,
    output logic        io_in_ready,
    input  logic [7:0]  io_in_bits,
    output logic        io_out_valid,
    input  logic        io_out_ready,
    output logic [7:0]  io_out_bits,
    output logic        io_out_last,
    output logic        io_err_checksum,
    output logic        io_err_length,
    output logic        io_err_timeout,
    output logic [15:0] io_frame_count
);

    localparam int unsigned IDXW = $clog2(MAX_PAYLOAD);
    localparam int unsigned LENW = $clog2(MAX_PAYLOAD + 1);
    localparam int unsigned TMW  = $clog2(TIMEOUT_CYCLES + 1);

    state_t          state, state_next;
    logic [LENW-1:0] len_q, len_next;
    logic [IDXW-1:0] idx_q, idx_next, rd_q, rd_next;
    logic [7:0]      sum_q, sum_next;
    logic [TMW-1:0]  idle_q, idle_next;
    logic [15:0]     count_next;
    logic            in_fire, out_fire, timed, wr_en;
    logic            err_len_next, err_chk_next, err_to_next;
    logic [7:0]      rd_data;

    assign in_fire  = io_in_valid && io_in_ready;
    assign out_fire = io_out_valid && io_out_ready;

    uart_frame_buffer #(
        .DEPTH (MAX_PAYLOAD),
        .AW    (IDXW)
    ) u_buffer (
        .clock     (clock),
        .wr_en     (wr_en),
        .wr_addr   (idx_q),
        .wr_data   (io_in_bits),
        .rd_addr   (rd_next),
        .rd_data_c (rd_data)
    );

    // Next-state, datapath updates, error detection and idle timeout.
    always_comb begin
        state_next   = state;
        len_next     = len_q;
        idx_next     = idx_q;
        rd_next      = rd_q;
        sum_next     = sum_q;
        count_next   = io_frame_count;
        err_len_next = 1'b0;
        err_chk_next = 1'b0;
        err_to_next  = 1'b0;
        wr_en        = 1'b0;
        idle_next    = '0;
        timed        = 1'b0;

        unique case (state)
            SYNC0: begin
                if (in_fire && io_in_bits == SYNC_BYTE) state_next = SYNC1;
            end
            SYNC1: begin
                if (in_fire) state_next = (io_in_bits == SYNC_BYTE) ? LEN : SYNC0;
                timed = 1'b1;
            end
            LEN: begin
                if (in_fire) begin
                    if (io_in_bits != 8'd0 && io_in_bits <= 8'(MAX_PAYLOAD)) begin
                        len_next   = LENW'(io_in_bits);
                        sum_next   = io_in_bits;
                        idx_next   = '0;
                        state_next = PAYLOAD;
                    end else begin
                        err_len_next = 1'b1;
                        state_next   = SYNC0;
                    end
                end
                timed = 1'b1;
            end
            PAYLOAD: begin
                if (in_fire) begin
                    wr_en    = 1'b1;
                    sum_next = checksum_add(sum_q, io_in_bits);
                    if (LENW'(idx_q) == len_q - LENW'(1)) state_next = CHECK;
                    else                                   idx_next   = idx_q + IDXW'(1);
                end
                timed = 1'b1;
            end
            CHECK: begin
                if (in_fire) begin
                    if (io_in_bits == sum_q) begin
                        count_next = io_frame_count + 16'd1;
                        rd_next    = '0;
                        state_next = DRAIN;
                    end else begin
                        err_chk_next = 1'b1;
                        state_next   = SYNC0;
                    end
                end
                timed = 1'b1;
            end
            DRAIN: begin
                if (out_fire) begin
                    if (LENW'(rd_q) == len_q - LENW'(1)) state_next = SYNC0;
                    else                                  rd_next    = rd_q + IDXW'(1);
                end
            end
            default: state_next = SYNC0;
        endcase

        // Idle cycles inside a frame; the TIMEOUT_CYCLES-th idle cycle abandons the frame.
        if (timed && !in_fire) begin
            if (idle_q == TMW'(TIMEOUT_CYCLES - 1)) begin
                err_to_next = 1'b1;
                state_next  = SYNC0;
            end else begin
                idle_next = idle_q + TMW'(1);
            end
        end
    end

    // State, datapath and registered outputs (derived from next state).
    always_ff @(posedge clock) begin
        if (!reset) begin
            state           <= SYNC0;
            len_q           <= '0;
            idx_q           <= '0;
            rd_q            <= '0;
            sum_q           <= '0;
            idle_q          <= '0;
            io_in_ready     <= 1'b1;
            io_out_valid    <= 1'b0;
            io_out_bits     <= '0;
            io_out_last     <= 1'b0;
            io_err_checksum <= 1'b0;
            io_err_length   <= 1'b0;
            io_err_timeout  <= 1'b0;
            io_frame_count  <= '0;
        end else begin
            state           <= state_next;
            len_q           <= len_next;
            idx_q           <= idx_next;
            rd_q            <= rd_next;
            sum_q           <= sum_next;
            idle_q          <= idle_next;
            io_in_ready     <= (state_next != DRAIN);
            io_out_valid    <= (state_next == DRAIN);
            io_out_bits     <= (state_next == DRAIN) ? rd_data : 8'd0;
            io_out_last     <= (state_next == DRAIN) && (LENW'(rd_next) == len_next - LENW'(1));
            io_err_checksum <= err_chk_next;
            io_err_length   <= err_len_next;
            io_err_timeout  <= err_to_next;
            io_frame_count  <= count_next;
        end
    end

endmodule

// File: doc/uart_frame_decoder.md
# uart_frame_decoder

Byte-stream framer that sits directly downstream of the UART receiver in the BiliArty100T SoC. It consumes raw received bytes and hunts for the two-byte sync preamble 0xCA 0xCA. It then captures a length-prefixed payload and checks an 8-bit additive checksum. Only verified payloads are forwarded, as a packetised byte stream, to the MLP policy command interface.

## Interface
- SYNC_BYTE, 8'hCA, preamble byte; two consecutive copies start a frame
- MAX_PAYLOAD, 16, largest legal LEN value; sets payload buffer depth
- TIMEOUT_CYCLES, 100_000, idle cycles tolerated between bytes inside a frame

- clock  in  1  single clock for all logic
- reset  in  1  synchronous, active-low reset
- io_in_valid  in  1  received byte available from the UART RX
- io_in_ready  out  1  decoder accepts byte this cycle
- io_in_bits  in  8  received byte
- io_out_valid  out  1  verified payload byte available
- io_out_ready  in  1  downstream accepts byte
- io_out_bits  out  8  payload byte
- io_out_last  out  1  high with the final payload byte of a frame
- io_err_checksum  out  1  one-cycle pulse on checksum mismatch
- io_err_length  out  1  one-cycle pulse on illegal LEN
- io_err_timeout  out  1  one-cycle pulse on intra-frame timeout
- io_frame_count  out  16  count of verified frames, wraps at 0xFFFF -> 0

## Operation
- Frame format: SYNC SYNC LEN P[0..LEN-1] CHK, where CHK = (LEN + ΣP) mod 256.
- A transfer occurs when valid && ready on the same rising edge.
- States:
  - SYNC0: byte == SYNC_BYTE -> SYNC1; any other byte stays in SYNC0.
  - SYNC1: byte == SYNC_BYTE -> LEN; any other byte -> SYNC0.
  - LEN:
    - 1 ≤ byte ≤ MAX_PAYLOAD: store LEN, set sum = byte, clear index -> PAYLOAD.
    - Otherwise: pulse io_err_length -> SYNC0. This includes a third SYNC_BYTE.
  - PAYLOAD: write byte to buffer[index], sum += byte, index++. When index reaches LEN-1 on this byte -> CHECK.
  - CHECK:
    - byte == sum: frame_count++ -> DRAIN.
    - Otherwise: pulse io_err_checksum and discard the buffer -> SYNC0.
  - DRAIN: present buffer[rd] on io_out_bits; advance rd on each output transfer. io_out_last = (rd == LEN-1). The transfer of the last byte -> SYNC0.
- io_in_ready = 1 in every state except DRAIN, where it is 0. No input bytes are accepted while draining.
- io_out_valid = 1 only in DRAIN.
- Timeout:
  - An idle counter runs in SYNC1, LEN, PAYLOAD and CHECK. It clears on every input transfer and on entry to those states.
  - Reaching TIMEOUT_CYCLES pulses io_err_timeout and forces SYNC0 on the next edge.
  - The counter does not run in SYNC0 or DRAIN.
- Arithmetic:
  - sum is 8 bits and wraps.
  - index and rd are $clog2(MAX_PAYLOAD) bits.
  - LEN is stored in $clog2(MAX_PAYLOAD+1) bits.

## Timing
- Reset (reset low at an edge) forces:
  - state = SYNC0
  - io_in_ready = 1, io_out_valid = 0, io_out_last = 0, io_out_bits = 0
  - all error pulses = 0
  - io_frame_count = 0, idle counter = 0
- Reset asserted mid-frame or mid-drain abandons the frame. No partial output and no error pulse are produced.
- Latency:
  - The CHK byte is accepted at edge N; io_out_valid is high from cycle N+1 with P[0].
  - Each later payload byte follows one cycle after the previous transfer when io_out_ready is held high.
  - A frame of LEN bytes therefore occupies LEN cycles in DRAIN minimum.
- Under backpressure (io_out_ready = 0), io_out_bits and io_out_last must hold stable.
- Error pulses are registered and asserted in the cycle after the offending transfer or timeout. They are mutually exclusive.
- io_frame_count updates in the cycle after CHK acceptance.
- In SYNC0, io_in_ready is 1 in the cycle immediately after the last output transfer.

## Structure
- Put these in a shared package uart_frame_pkg:
  - the state enum typedef (SYNC0, SYNC1, LEN, PAYLOAD, CHECK, DRAIN)
  - the default SYNC_BYTE and MAX_PAYLOAD constants
  - a checksum helper function, shared with the bench's frame builder
- One sub-module, uart_frame_buffer: an MAX_PAYLOAD×8 register file with a single write port and a single read port, addressed by index and rd.
- The FSM, counters and error logic live in the top module.

## Test plan
- Good frame: CA CA 03 01 02 03 09 with io_out_ready = 1.
  - Output is 01, 02, 03 on consecutive cycles starting one cycle after 09 is accepted; last is high on 03.
  - io_frame_count = 1; no error pulses.
- Bad checksum: CA CA 03 01 02 03 0A.
  - io_err_checksum pulses once; no output beats; io_frame_count unchanged.
  - A following good frame decodes normally.
- Garbage and illegal length:
  - Stream 55 CA 55 CA CA 01 7F 80: a single beat 7F with last = 1 is output.
  - Then CA CA 00 and, separately, CA CA 11: each pulses io_err_length once and returns to SYNC0.
- Backpressure: good frame CA CA 02 AA 55 01 with io_out_ready low for 5 cycles after valid rises.
  - AA is held stable throughout; io_in_ready stays 0.
  - Then AA and 55 (last) are output; io_in_ready returns to 1 next cycle.
- Timeout: CA CA 02 10, then no input for TIMEOUT_CYCLES (set 50 in the bench).
  - io_err_timeout pulses once.
  - A subsequent CA CA 01 42 43 outputs 42 with last = 1.
- Reset mid-frame: assert reset for 2 cycles after CA CA 04 11 22.
  - All outputs return to reset values; no output beats; io_frame_count = 0.
  - The next good frame is accepted.
